// File: rtl/bridge_tx.sv
// ============================================================================
//  Module   : bridge_tx
//  Purpose  : Turns bus read responses into "M<hhhh>\r\n" bytes for the UART.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bridge_tx #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [0:0]    state_q, state_d;
  logic [15:0]   sh_q, sh_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;

  logic w_full, w_push_req, w_push, w_pop, w_hs;
  logic unused_bus;

  // Address and write data are carried on the bus but not needed here.
  assign unused_bus = ^{addr_i, wdata_i};

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_full     = (count_q == CW'(FIFO_DEPTH));
  assign w_push_req = valid_i && !rw_i;
  assign w_pop      = (state_q == ST_IDLE) && (count_q != '0);
  // A pop in the same cycle frees the slot the push lands in.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_hs       = tx_valid_q && tx_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (w_push_req && !w_push) ovf_d = 1'b1;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= rdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_pop) state_d = ST_SEND;
      ST_SEND: if (w_hs && idx_q == 3'd6) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next-byte values are computed here and registered so the UART never sees
  // a combinational path from tx_ready_i.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    sh_d       = sh_q;
    idx_d      = idx_q;
    case (state_q)
      ST_IDLE: begin
        tx_valid_d = 1'b0;
        if (w_pop) begin
          sh_d       = mem_q[rd_ptr_q];
          idx_d      = 3'd0;
          tx_data_d  = 8'h4D;
          tx_valid_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_hs) begin
          idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              tx_data_d = hex_ascii(sh_q[15:12]);
              sh_d      = {sh_q[11:0], 4'h0};
            end
            3'd4:    tx_data_d = 8'h0D;
            3'd5:    tx_data_d = 8'h0A;
            default: begin
              tx_valid_d = 1'b0;
              idx_d      = 3'd0;
            end
          endcase
        end
      end
      default: tx_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      sh_q       <= '0;
      idx_q      <= 3'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      sh_q       <= sh_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bridge_tx.sv
// ============================================================================
//  Module   : tb_bridge_tx
//  Purpose  : Self-checking bench for bridge_tx against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bridge_tx;

  localparam int DEPTH = 8;
  localparam logic [7:0] BEEF_EXP [7] = '{8'h4D, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};

  logic        clk = 1'b1;
  logic        rst_n;
  logic [15:0] addr_i, wdata_i, rdata_i;
  logic        rw_i, valid_i, tx_ready_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o, overflow_o;

  always #5 clk = ~clk;

  bridge_tx #(.FIFO_DEPTH(DEPTH)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_i    (rdata_i),
    .rw_i       (rw_i),
    .valid_i    (valid_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .overflow_o (overflow_o)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: word FIFO plus the bytes still owed for the current message.
  logic [15:0] m_fifo [$];
  logic [7:0]  m_msg  [$];
  logic        m_ovf  = 1'b0;
  logic [7:0]  m_data = 8'h00;
  logic [7:0]  log_q  [$];
  logic [15:0] exp_w  [$];
  bit          chk_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] msg_byte(input logic [15:0] w, input int i);
    case (i)
      0:       return 8'h4D;
      5:       return 8'h0D;
      6:       return 8'h0A;
      default: return hexc(w[(4 - i) * 4 +: 4]);
    endcase
  endfunction

  task automatic model_step();
    logic [15:0] w;
    bit hs, pop, push;
    if (!rst_n) begin
      m_fifo.delete();
      m_msg.delete();
      m_ovf  = 1'b0;
      m_data = 8'h00;
      return;
    end
    hs   = (m_msg.size() > 0) && tx_ready_i;
    pop  = (m_msg.size() == 0) && (m_fifo.size() > 0);
    push = valid_i && !rw_i;
    if (hs) void'(m_msg.pop_front());
    if (pop) begin
      w = m_fifo.pop_front();
      for (int i = 0; i < 7; i++) m_msg.push_back(msg_byte(w, i));
    end
    if (push) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(rdata_i);
      else                       m_ovf = 1'b1;
    end
    if (m_msg.size() > 0) m_data = m_msg[0];
  endtask

  task automatic cycle(input bit v, input bit rw, input logic [15:0] rd, input bit rdy, input bit rn);
    valid_i    = v;
    rw_i       = rw;
    rdata_i    = rd;
    tx_ready_i = rdy;
    rst_n      = rn;
    addr_i     = 16'($urandom);
    wdata_i    = 16'($urandom);
    @(negedge clk);
    if (chk_en) begin
      check_val("tx_valid", 32'(tx_valid_o), 32'(m_msg.size() > 0));
      check_val("tx_data",  32'(tx_data_o),  32'(m_data));
      check_val("overflow", 32'(overflow_o), 32'(m_ovf));
    end
    if (tx_valid_o && rdy) log_q.push_back(tx_data_o);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, rdy, 1'b1);
  endtask

  task automatic check_log(input string tag);
    int k;
    k = 0;
    check_val({tag, "_len"}, 32'(log_q.size()), 32'(exp_w.size() * 7));
    foreach (exp_w[w]) begin
      for (int i = 0; i < 7; i++) begin
        if (k < log_q.size()) check_val(tag, 32'(log_q[k]), 32'(msg_byte(exp_w[w], i)));
        k++;
      end
    end
    log_q.delete();
    exp_w.delete();
  endtask

  initial begin
    bit done;

    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    check_val("rst_valid", 32'(tx_valid_o), 32'd0);
    check_val("rst_data",  32'(tx_data_o),  32'd0);
    check_val("rst_ovf",   32'(overflow_o), 32'd0);

    // Single read with literal expected bytes
    log_q.delete();
    cycle(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1);
    idle(10, 1'b1);
    check_val("beef_len", 32'(log_q.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < log_q.size()) check_val("beef_byte", 32'(log_q[i]), 32'(BEEF_EXP[i]));
    log_q.delete();

    // Writes are filtered
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 16'h0009, 1'b1, 1'b1);
    idle(12, 1'b1);
    exp_w.push_back(16'h0009);
    check_log("wr_filter");

    // Back-pressure: ready every third cycle
    cycle(1'b1, 1'b0, 16'hA5C3, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 16'h0, (i % 3) == 2, 1'b1);
    exp_w.push_back(16'hA5C3);
    check_log("backpress");

    // Burst of ten reads into a stalled transmitter
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0, 1'b1);
    idle(3, 1'b0);
    check_val("burst_ovf_set", 32'(overflow_o), 32'd1);
    idle(9 * 8 + 4, 1'b1);
    for (int i = 0; i < 9; i++) exp_w.push_back(16'(i));
    check_log("burst");
    check_val("burst_ovf_sticky", 32'(overflow_o), 32'd1);

    // Full FIFO with a push landing on the IDLE pop
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    log_q.delete();
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0, 1'b1);
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!done && m_msg.size() == 0 && m_fifo.size() == DEPTH) begin
        cycle(1'b1, 1'b0, 16'h01FF, 1'b1, 1'b1);
        done = 1'b1;
      end else begin
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      end
    end
    check_val("fullpop_hit", 32'(done), 32'd1);
    check_val("fullpop_ovf", 32'(overflow_o), 32'd0);
    idle(9 * 8 + 4, 1'b1);
    for (int i = 0; i < 9; i++) exp_w.push_back(16'h0100 + 16'(i));
    exp_w.push_back(16'h01FF);
    check_log("fullpop");

    // Reset in the middle of a message
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    log_q.delete();
    cycle(1'b1, 1'b0, 16'h1234, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (m_msg.size() == 4) break;
      cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    end
    check_val("mid_reached", 32'(m_msg.size() == 4), 32'd1);
    check_val("mid_prefix_len", 32'(log_q.size()), 32'd3);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    check_val("mid_rst_valid", 32'(tx_valid_o), 32'd0);
    check_val("mid_rst_ovf",   32'(overflow_o), 32'd0);
    log_q.delete();
    idle(10, 1'b1);
    check_val("mid_silent", 32'(log_q.size()), 32'd0);
    cycle(1'b1, 1'b0, 16'h00FF, 1'b1, 1'b1);
    idle(12, 1'b1);
    exp_w.push_back(16'h00FF);
    check_log("mid_new");

    // Random traffic, back-pressure and occasional resets against the model
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 16'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 299) != 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
